// File: rtl/irq_collector.sv
// Device interrupt conditioner for cp0: per-line synchroniser, glitch filter,
// level/edge qualification and enable, feeding a registered ir_map.
module irq_collector #(
  parameter int IRQ_LINES   = 30,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IRQ_LINES:1]   irq_in,
  input  logic [IRQ_LINES:1]   edge_sel,
  input  logic [IRQ_LINES:1]   irq_en,
  output logic [IRQ_LINES:1]   ir_map,
  output logic [IRQ_LINES:1]   irq_level
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  // Stage 0 takes the raw lines; the last stage is the synchronised level.
  logic [SYNC_STAGES-1:0][IRQ_LINES:1] r_sync;
  logic [IRQ_LINES:1]                  w_s;
  logic [IRQ_LINES:1]                  w_f;
  logic [IRQ_LINES:1]                  r_f_prev;
  logic [IRQ_LINES:1]                  r_ir_map;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], irq_in};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  if (FILTER_LEN == 0) begin : g_bypass
    assign w_f = w_s;
  end else begin : g_filter
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [CNT_W-1:0]   r_cnt [IRQ_LINES:1];
    logic [IRQ_LINES:1] r_f;

    // Any cycle where s agrees with f restarts the persistence count.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_f <= '0;
        for (int i = 1; i <= IRQ_LINES; i++) begin
          r_cnt[i] <= '0;
        end
      end else begin
        for (int i = 1; i <= IRQ_LINES; i++) begin
          if (w_s[i] == r_f[i]) begin
            r_cnt[i] <= '0;
          end else if (r_cnt[i] != CNT_LAST) begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end else begin
            r_f[i]   <= w_s[i];
            r_cnt[i] <= '0;
          end
        end
      end
    end

    assign w_f = r_f;
  end

  // edge_sel/irq_en are quasi-static config and are used unsynchronised here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_f_prev <= '0;
      r_ir_map <= '0;
    end else begin
      r_f_prev <= w_f;
      r_ir_map <= irq_en & ((edge_sel & w_f & ~r_f_prev) | (~edge_sel & w_f));
    end
  end

  assign ir_map    = r_ir_map;
  assign irq_level = w_f;

endmodule

// File: tb/tb_irq_collector.sv
// Bench for irq_collector: default build plus a filter-bypass build, both
// checked every cycle against a window-based behavioural model.
module tb_irq_collector;

  localparam int N    = 30;
  localparam int SYNC = 2;
  localparam int FL0  = 4;

  logic         clk;
  logic         rst_n;
  logic [N:1]   irq_in;
  logic [N:1]   edge_sel;
  logic [N:1]   irq_en;
  logic [N:1]   map0, lvl0, map1, lvl1;

  int n_checks;
  int n_fail;
  bit chk_on;

  irq_collector #(.IRQ_LINES(N), .SYNC_STAGES(SYNC), .FILTER_LEN(FL0)) u_dut_f4 (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .edge_sel(edge_sel),
    .irq_en(irq_en), .ir_map(map0), .irq_level(lvl0)
  );

  irq_collector #(.IRQ_LINES(N), .SYNC_STAGES(SYNC), .FILTER_LEN(0)) u_dut_f0 (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .edge_sel(edge_sel),
    .irq_en(irq_en), .ir_map(map1), .irq_level(lvl1)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Model: f flips once the last FL sampled s values all disagree with it.
  logic [N:1] m_pipe [2][SYNC];
  logic [N:1] m_win  [2][FL0];
  logic [N:1] m_f    [2];
  logic [N:1] m_fp   [2];
  logic [N:1] m_map  [2];
  logic [N:1] m_lvl  [2];

  always @(posedge clk) begin : model
    logic [N:1] s, fc, nf;
    bit         all_diff;
    int         fl;
    for (int m = 0; m < 2; m++) begin
      fl = (m == 0) ? FL0 : 0;
      if (!rst_n) begin
        m_f[m]   <= '0;
        m_fp[m]  <= '0;
        m_map[m] <= '0;
        m_lvl[m] <= '0;
        for (int j = 0; j < SYNC; j++) m_pipe[m][j] <= '0;
        for (int j = 0; j < FL0; j++) m_win[m][j] <= '0;
      end else begin
        s  = m_pipe[m][SYNC-1];
        fc = (fl == 0) ? s : m_f[m];
        m_map[m] <= irq_en & ((edge_sel & fc & ~m_fp[m]) | (~edge_sel & fc));
        m_fp[m]  <= fc;
        nf = fc;
        if (fl > 0) begin
          for (int i = 1; i <= N; i++) begin
            all_diff = (s[i] != fc[i]);
            for (int j = 0; j < fl - 1; j++) begin
              if (m_win[m][j][i] == fc[i]) all_diff = 1'b0;
            end
            if (all_diff) nf[i] = ~fc[i];
          end
          m_win[m][0] <= s;
          for (int j = 1; j < FL0; j++) m_win[m][j] <= m_win[m][j-1];
        end
        m_f[m] <= nf;
        m_pipe[m][0] <= irq_in;
        for (int j = 1; j < SYNC; j++) m_pipe[m][j] <= m_pipe[m][j-1];
        m_lvl[m] <= (fl == 0) ? m_pipe[m][SYNC-2] : nf;
      end
    end
  end

  // scoreboard: every cycle, both builds against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("map_f4", 32'(map0), 32'(m_map[0]));
      check("lvl_f4", 32'(lvl0), 32'(m_lvl[0]));
      check("map_f0", 32'(map1), 32'(m_map[1]));
      check("lvl_f0", 32'(lvl1), 32'(m_lvl[1]));
    end
  end

  // driver tasks
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // pat bit k-1 is irq_in[line] for sampling edge k; irq_en[line] set at edge en_k.
  task automatic watch(input int n, input int line, input logic [63:0] pat, input int en_k,
                       output int mc, output int mf, output int lc, output int lf);
    mc = 0; mf = 0; lc = 0; lf = 0;
    for (int k = 1; k <= n; k++) begin
      irq_in[line] = (k <= 64) ? pat[k-1] : 1'b0;
      if (k == en_k) irq_en[line] = 1'b1;
      @(negedge clk);
      if (map0[line]) begin
        mc++;
        if (mf == 0) mf = k;
      end
      if (lvl0[line]) begin
        lc++;
        if (lf == 0) lf = k;
      end
    end
  endtask

  initial begin
    int mc, mf, lc, lf, idx;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    irq_in   = '1;
    edge_sel = '1;
    irq_en   = '1;
    chk_on   = 1'b1;

    // reset with all lines high, then one all-ones pulse after release
    repeat (3) begin
      @(negedge clk);
      check("t1_rst_map0", 32'(map0), 32'd0);
      check("t1_rst_lvl0", 32'(lvl0), 32'd0);
      check("t1_rst_map1", 32'(map1), 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("t1_map0", 32'(map0), (k == 7) ? 32'h3fff_ffff : 32'd0);
      check("t1_map1", 32'(map1), (k == 3) ? 32'h3fff_ffff : 32'd0);
    end
    irq_in = '0;
    settle(12);

    // edge mode, long high on line 5
    watch(30, 5, 64'hF_FFFF, 0, mc, mf, lc, lf);
    check("t2_pulses", 32'(mc), 32'd1);
    check("t2_pulse_at", 32'(mf), 32'd7);
    check("t2_level_at", 32'(lf), 32'd6);
    settle(12);

    // glitch rejection then the shortest accepted pulse
    watch(20, 3, 64'h7, 0, mc, mf, lc, lf);
    check("t3_glitch_map", 32'(mc), 32'd0);
    check("t3_glitch_lvl", 32'(lc), 32'd0);
    settle(12);
    watch(20, 3, 64'hF, 0, mc, mf, lc, lf);
    check("t3_min_pulses", 32'(mc), 32'd1);
    check("t3_min_at", 32'(mf), 32'd7);
    settle(12);

    // level mode on line 30, plain and with a short low gap
    edge_sel[30] = 1'b0;
    watch(30, 30, 64'h3FF, 0, mc, mf, lc, lf);
    check("t4_len", 32'(mc), 32'd10);
    check("t4_at", 32'(mf), 32'd7);
    settle(12);
    watch(35, 30, 64'hFCF, 0, mc, mf, lc, lf);
    check("t4_gap_len", 32'(mc), 32'd12);
    check("t4_gap_at", 32'(mf), 32'd7);
    edge_sel[30] = 1'b1;
    settle(12);

    // enable raised after the qualifying edge
    irq_en[1] = 1'b0;
    watch(30, 1, 64'hF_FFFF, 9, mc, mf, lc, lf);
    check("t5_edge_lost", 32'(mc), 32'd0);
    settle(12);
    irq_en[1]   = 1'b0;
    edge_sel[1] = 1'b0;
    watch(30, 1, 64'hF_FFFF, 9, mc, mf, lc, lf);
    check("t5_level_at", 32'(mf), 32'd9);
    edge_sel[1] = 1'b1;
    settle(12);

    // reset during a filter count discards it
    irq_in = '1;
    settle(4);
    rst_n = 1'b0;
    settle(1);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check("t6_map0", 32'(map0), (k == 7) ? 32'h3fff_ffff : 32'd0);
      check("t6_map1", 32'(map1), (k == 3) ? 32'h3fff_ffff : 32'd0);
    end
    irq_in = '0;
    settle(12);

    // randomized traffic, config changes and occasional resets
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 2) == 0) begin
        idx = $urandom_range(1, N);
        irq_in[idx] = ~irq_in[idx];
      end
      if ($urandom_range(0, 29) == 0) irq_in = irq_in ^ N'($urandom);
      if ($urandom_range(0, 39) == 0) edge_sel = N'($urandom);
      if ($urandom_range(0, 39) == 0) irq_en = N'($urandom);
    end
    rst_n = 1'b1;
    settle(12);

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
